ipfw_axil_reg_slave: RTL and testbench

AXI4-Lite responder that terminates the master port of the IPFW block design. It holds NUM_REGS 32-bit control registers that the master writes and reads back. The register contents are exported in parallel to downstream IPFW logic. It supports one outstanding write and one outstanding read, which run independently of each other.

---
 rtl/ipfw_axil_reg_slave.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ipfw_axil_reg_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipfw_axil_reg_slave.sv
// ============================================================================
// ipfw_axil_reg_slave
// ----------------------------------------------------------------------------
// AXI4-Lite responder terminating the IPFW master port. Holds NUM_REGS 32-bit
// read/write control registers and exports them in parallel on reg_out.
// One outstanding write and one outstanding read, each with its own small
// FSM, so the two channels run fully independently.
//
// Optional feature (compile-time macro IPFW_ACCESS_CNT_EN):
//   When defined, register index NUM_REGS decodes to a read-only 32-bit
//   counter of write commits that returned OKAY. Writes to it get SLVERR.
//   Requires NUM_REGS < 2^(C_S_AXI_ADDR_WIDTH-2).
//   When undefined, that index is out of range like any other (SLVERR).
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   AW*/W*/B*             write address / data / response channels
//   AR*/R*                read address / data channels
//   AWPROT, ARPROT        accepted and ignored
//   reg_out               register i at bits [32i+31:32i]
// ============================================================================
module ipfw_axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

    localparam int DW   = C_S_AXI_DATA_WIDTH;
    localparam int NB   = DW / 8;
    localparam int IDXW = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One extra bit so an index can be compared against NUM_REGS even when
    // NUM_REGS fills the whole index space.
    typedef logic [IDXW:0] idx_ext_t;
    localparam idx_ext_t NUM_REGS_EXT = idx_ext_t'(NUM_REGS);

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_RESP } rstate_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wstate_e                     w_state_q, w_state_d;
    logic                        aw_held_q, aw_held_d;
    logic [IDXW-1:0]             aw_idx_q,  aw_idx_d;
    logic                        w_held_q,  w_held_d;
    logic [DW-1:0]               w_data_q,  w_data_d;
    logic [NB-1:0]               w_strb_q,  w_strb_d;
    logic                        bvalid_q,  bvalid_d;
    logic [1:0]                  bresp_q,   bresp_d;
    logic [NUM_REGS-1:0][DW-1:0] regs_q,    regs_d;

    rstate_e                     r_state_q, r_state_d;
    logic                        rvalid_q,  rvalid_d;
    logic [1:0]                  rresp_q,   rresp_d;
    logic [DW-1:0]               rdata_q,   rdata_d;

`ifdef IPFW_ACCESS_CNT_EN
    localparam logic [IDXW-1:0] CNT_IDX = IDXW'(NUM_REGS);
    logic [31:0]                 cnt_q,     cnt_d;
`endif

    // Address LSBs and protection bits carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // ------------------------------------------------------------------
    // Handshakes. Readies are forced low while reset is asserted so nothing
    // is accepted on the reset edge itself.
    // ------------------------------------------------------------------
    assign AWREADY = !ARESET && (w_state_q == W_IDLE) && !aw_held_q;
    assign WREADY  = !ARESET && (w_state_q == W_IDLE) && !w_held_q;
    assign ARREADY = !ARESET && (r_state_q == R_IDLE);

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // Effective write beat: the held copy if present, otherwise the beat
    // handshaking right now. Lets AW and W meet in any order or together.
    logic [IDXW-1:0] wr_idx;
    logic [DW-1:0]   wr_data;
    logic [NB-1:0]   wr_strb;
    logic            wr_ok;
    logic            commit;

    assign wr_idx  = aw_held_q ? aw_idx_q : AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_held_q  ? w_data_q : WDATA;
    assign wr_strb = w_held_q  ? w_strb_q : WSTRB;
    assign wr_ok   = {1'b0, wr_idx} < NUM_REGS_EXT;
    assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // ------------------------------------------------------------------
    // Write channel next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
`ifdef IPFW_ACCESS_CNT_EN
        cnt_d     = cnt_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = WDATA;
                    w_strb_d = WSTRB;
                end
                if (commit) begin
                    // Commit overrides the latch above: nothing stays held.
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (wr_ok) begin
                        bresp_d = RESP_OKAY;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (wr_idx == IDXW'(i)) begin
                                for (int b = 0; b < NB; b++) begin
                                    if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                                end
                            end
                        end
`ifdef IPFW_ACCESS_CNT_EN
                        cnt_d = cnt_q + 32'd1;
`endif
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read channel. The mux reads the current (pre-commit) register
    // contents, so a read and a write to the same register on one edge
    // returns the old value.
    // ------------------------------------------------------------------
    logic [IDXW-1:0] rd_idx;
    logic            rd_ok;
    logic [DW-1:0]   rd_sel;

    assign rd_idx = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        rd_sel = '0;
        rd_ok  = {1'b0, rd_idx} < NUM_REGS_EXT;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDXW'(i)) rd_sel = regs_q[i];
        end
`ifdef IPFW_ACCESS_CNT_EN
        if (rd_idx == CNT_IDX) begin
            rd_sel = cnt_q;
            rd_ok  = 1'b1;
        end
`endif
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d  = 1'b1;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rdata_d   = rd_sel;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            regs_q    <= '0;
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
`ifdef IPFW_ACCESS_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
            r_state_q <= r_state_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
`ifdef IPFW_ACCESS_CNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;
    assign reg_out = regs_q;

endmodule

// File: tb/tb_ipfw_axil_reg_slave.sv
module tb_ipfw_axil_reg_slave;

    localparam int AW = 5;
    localparam int NR = 4;

    logic          ACLK, ARESET;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]   WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic [NR*32-1:0] reg_out;

    ipfw_axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [NR];
    logic [31:0] m_cnt;

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_cnt = '0;
    endtask

    function automatic logic [1:0] m_wresp(input int idx);
        return (idx < NR) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [1:0] m_rresp(input int idx);
`ifdef IPFW_ACCESS_CNT_EN
        if (idx == NR) return 2'b00;
`endif
        return (idx < NR) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] m_rdata(input int idx);
`ifdef IPFW_ACCESS_CNT_EN
        if (idx == NR) return m_cnt;
`endif
        return (idx < NR) ? m_regs[idx] : 32'h0;
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (idx < NR) begin
            m_regs[idx] = (m_regs[idx] & ~mask) | (d & mask);
            m_cnt = m_cnt + 1;
        end
    endtask

    function automatic logic [NR*32-1:0] m_regout();
        logic [NR*32-1:0] r;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = m_regs[i];
        return r;
    endfunction

    // ---------------- bus tasks (called at posedge+1) ----------------
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int c = 0;
        resp = 2'b11;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        while (!(aw_done && w_done) && c < 50) begin
            AWVALID = !aw_done && (c >= aw_dly);
            WVALID  = !w_done  && (c >= w_dly);
            if (w_done && !aw_done) chk("w_held_rdy", {WREADY, BVALID}, 2'b00);
            if (aw_done && !w_done) chk("aw_held_rdy", {AWREADY, BVALID}, 2'b00);
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            @(posedge ACLK); #1; c++;
        end
        AWVALID = 0; WVALID = 0;
        if (!(aw_done && w_done)) begin
            chk("w_timeout", 0, 1);
            return;
        end
        chk("bvalid_lat", BVALID, 1);
        resp = BRESP;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge ACLK); #1;
            chk("b_hold", {BVALID, AWREADY, WREADY, BRESP}, {3'b100, resp});
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        chk("b_done", {BVALID, AWREADY, WREADY}, 3'b011);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        bit done = 0;
        int c = 0;
        data = '0; resp = 2'b11;
        ARADDR = addr;
        while (!done && c < 50) begin
            ARVALID = (c >= ar_dly);
            if (ARVALID && ARREADY) done = 1;
            @(posedge ACLK); #1; c++;
        end
        ARVALID = 0;
        if (!done) begin
            chk("ar_timeout", 0, 1);
            return;
        end
        chk("rvalid_lat", RVALID, 1);
        data = RDATA; resp = RRESP;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge ACLK); #1;
            chk("r_hold", {RVALID, ARREADY, RDATA, RRESP}, {2'b10, data, resp});
        end
        RREADY = 1;
        @(posedge ACLK); #1;
        RREADY = 0;
        chk("r_done", {RVALID, ARREADY}, 2'b01);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd);
        logic [1:0] r;
        axi_write(addr, d, s, awd, wd, bd, r);
        chk("bresp", r, m_wresp(int'(addr[AW-1:2])));
        m_write(int'(addr[AW-1:2]), d, s);
        chk("reg_out", reg_out, m_regout());
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int ard, input int rd, output logic [31:0] d);
        logic [1:0] r;
        axi_read(addr, ard, rd, d, r);
        chk("rresp", r, m_rresp(int'(addr[AW-1:2])));
        chk("rdata", d, m_rdata(int'(addr[AW-1:2])));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d5;
        logic [1:0]  r5;
        ARESET = 1; AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0;
        WVALID = 0; BREADY = 0; ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
        m_reset();
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
        chk("rst_valid", {BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
        chk("rst_regout", reg_out, '0);
        ARESET = 0;
        @(posedge ACLK); #1;
        chk("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

        // 1: basic write/read of all registers
        for (int i = 0; i < NR; i++) do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < NR; i++) do_read(AW'(4 * i), 0, 0, d);
        chk("t1_regout", reg_out, 128'h00000004_00000003_00000002_00000001);

        // 2: byte strobes
        do_write(5'h00, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
        do_write(5'h00, 32'h11223344, 4'b0101, 0, 0, 0);
        do_read(5'h00, 0, 0, d);
        chk("t2_value", d, 32'hAA22CC44);

        // 3: W three cycles before AW, BREADY held off 5 cycles
        do_write(5'h08, 32'hC0FFEE01, 4'hF, 3, 0, 5);
        do_write(5'h0C, 32'h12345678, 4'b0000, 0, 0, 2);

        // 4: out-of-range write and read
        do_write(5'h14, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(5'h14, 0, 0, d);
        do_read(5'h1C, 1, 2, d);

        // 5: simultaneous write commit and read of the same register
        do_write(5'h04, 32'h5, 4'hF, 0, 0, 0);
        fork
            axi_write(5'h04, 32'h9, 4'hF, 0, 0, 0, r5);
            axi_read(5'h04, 0, 0, d5, r5);
        join
        chk("t5_prewrite", d5, 32'h5);
        m_write(1, 32'h9, 4'hF);
        do_read(5'h04, 0, 0, d);
        chk("t5_postwrite", d, 32'h9);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            a = {3'($urandom_range(0, 7)), 2'($urandom)};
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d);
        end

        // reset in the middle of a write: AW accepted, then reset
        AWADDR = 5'h00; AWVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0;
        ARESET = 1;
        @(posedge ACLK); #1;
        ARESET = 0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            chk("midrst_nob", BVALID, 1'b0);
            @(posedge ACLK); #1;
        end
        chk("midrst_regout", reg_out, '0);
        chk("midrst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
`ifdef IPFW_ACCESS_CNT_EN
        do_read(AW'(4 * NR), 0, 0, d);
        chk("cnt_after_rst", d, 32'h0);
        // 6: 3 OKAY writes + 1 SLVERR write (to the counter itself)
        do_write(5'h00, 32'h1, 4'hF, 0, 0, 0);
        do_write(5'h04, 32'h2, 4'hF, 1, 0, 0);
        do_write(5'h08, 32'h3, 4'hF, 0, 1, 0);
        do_write(AW'(4 * NR), 32'hFFFF, 4'hF, 0, 0, 0);
        do_read(AW'(4 * NR), 0, 0, d);
        chk("t6_count", d, 32'h3);
`else
        do_read(5'h00, 0, 0, d);
        do_read(AW'(4 * NR), 0, 0, d);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
